// File: rtl/my_boot_loader.sv
// Boot sequencer: streams words into instruction ROM from address 0 while holding the CPU in reset.
// Optional checksum verification of the loaded image is enabled by defining MY_BOOT_LOADER_CHECKSUM_EN.
module my_boot_loader #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [15:0]       expected_sum,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              rom_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [15:0]         rom_data_q, rom_data_d;
    logic                rom_we_q, rom_we_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                handshake;
    logic                sum_bad;
    logic [ADDR_W-1:0]   ptr;

    // The low bits of the word counter double as the write pointer.
    assign ptr       = word_count_q[ADDR_W-1:0];
    assign handshake = in_valid && (state_q == S_LOAD);

`ifdef MY_BOOT_LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d, sum_next;
    assign sum_next = sum_q + in_data;
    assign sum_bad  = (sum_next != expected_sum);

    always_ff @(posedge clk) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    always_comb begin
        sum_d = sum_q;
        if (state_q != S_LOAD && start)  sum_d = '0;
        else if (handshake)              sum_d = sum_next;
    end
`else
    logic [15:0] unused_expected_sum;
    assign unused_expected_sum = expected_sum;
    assign sum_bad             = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            word_count_q <= '0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            rom_we_q     <= 1'b0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            rom_we_q     <= rom_we_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        rom_addr_d   = rom_addr_q;
        rom_data_d   = rom_data_q;
        rom_we_d     = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                word_count_d = '0;
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (handshake) begin
                    rom_data_d   = in_data;
                    rom_addr_d   = ptr;
                    rom_we_d     = 1'b1;
                    word_count_d = word_count_q + (ADDR_W+1)'(1);
                    if (in_last) begin
                        state_d    = sum_bad ? S_ERROR : S_HOLD;
                        hold_cnt_d = HOLD_INIT;
                    end else if (ptr == ADDR_MAX) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) state_d    = S_RUN;
                else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
            S_RUN, S_ERROR: begin
                if (start) begin
                    state_d      = S_LOAD;
                    word_count_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_LOAD);
        busy       = (state_q == S_LOAD) || (state_q == S_HOLD);
        done       = (state_q == S_RUN);
        error      = (state_q == S_ERROR);
        cpu_reset  = (state_q != S_RUN);
        rom_addr   = rom_addr_q;
        rom_data   = rom_data_q;
        rom_we     = rom_we_q;
        word_count = word_count_q;
    end

endmodule

// File: tb/tb_my_boot_loader.sv
// Scoreboard bench for my_boot_loader: ROM writes are queued by the driver and checked by a monitor.
// Session outcomes come from a word-level model (checksum rule applies when MY_BOOT_LOADER_CHECKSUM_EN is defined).
module tb_my_boot_loader;

    localparam int AW = 2;
    localparam int HC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [15:0]   expected_sum = '0;
    logic          in_ready, rom_we, cpu_reset, busy, done, error;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [AW:0]   word_count;

    always #5 clk = ~clk;

    my_boot_loader #(.ADDR_W(AW), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .expected_sum(expected_sum),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_we(rom_we),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;
    wr_t exp_q[$];
    logic [15:0] words[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ROM write must match the oldest predicted write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rom_we_unexpected actual=1 expected=0 addr=%h t=%0t", rom_addr, $time);
            end else begin
                e = exp_q.pop_front();
                chk("rom_addr", 32'(rom_addr), 32'(e.addr));
                chk("rom_data", 32'(rom_data), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 1);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_rom_we"}, 32'(rom_we), 0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_rom_data"}, 32'(rom_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_word_count"}, 32'(word_count), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        in_data = 16'($urandom);
        step();
        start = 1'b0;
        chk("start_in_ready", 32'(in_ready), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_error", 32'(error), 0);
        chk("start_cpu_reset", 32'(cpu_reset), 1);
        chk("start_word_count", 32'(word_count), 0);
    endtask

    // Sends words[0..n-1]; a session that neither finishes nor overflows is aborted by reset.
    task automatic run_session(input int n, input bit last_final, input bit toggle, input logic [15:0] es);
        int acc = 0;
        bit ended = 0;
        bit err = 0;
        logic [15:0] sum = '0;
        expected_sum = es;
        do_start();
        for (int i = 0; i < n && !ended; i++) begin
            if (toggle && i > 0) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_last  = 1'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data  = words[i];
            in_last  = last_final && (i == n - 1);
            chk("load_in_ready", 32'(in_ready), 1);
            exp_q.push_back({AW'(acc), words[i]});
            step();
            acc++;
            sum = sum + words[i];
            if (in_last) begin
                ended = 1;
`ifdef MY_BOOT_LOADER_CHECKSUM_EN
                err = (sum != es);
`endif
            end else if (acc == (1 << AW)) begin
                ended = 1;
                err = 1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ended) begin
            chk("partial_in_ready", 32'(in_ready), 1);
            chk("partial_word_count", 32'(word_count), 32'(acc));
            reset    = 1'b1;
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            step();
            reset    = 1'b0;
            in_valid = 1'b0;
            chk_reset_values("midload_reset");
        end else if (err) begin
            chk("err_error", 32'(error), 1);
            chk("err_cpu_reset", 32'(cpu_reset), 1);
            chk("err_in_ready", 32'(in_ready), 0);
            chk("err_busy", 32'(busy), 0);
            chk("err_word_count", 32'(word_count), 32'(acc));
            step();
        end else begin
            for (int c = 0; c < HC; c++) begin
                chk("hold_cpu_reset", 32'(cpu_reset), 1);
                chk("hold_busy", 32'(busy), 1);
                chk("hold_in_ready", 32'(in_ready), 0);
                step();
            end
            chk("run_cpu_reset", 32'(cpu_reset), 0);
            chk("run_done", 32'(done), 1);
            chk("run_busy", 32'(busy), 0);
            chk("run_word_count", 32'(word_count), 32'(acc));
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        logic [15:0] s;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk_reset_values("post_reset");

        words[0] = 16'h0002; words[1] = 16'hEC10; words[2] = 16'h0003;
        run_session(3, 1, 0, 16'hEC15);
        run_session(3, 1, 1, 16'hEC15);

        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        run_session(4, 0, 0, 16'h0000);

        for (int i = 0; i < 5; i++) words[i] = 16'($urandom);
        run_session(2, 0, 0, 16'h0000);
        run_session(3, 1, 0, words[0] + words[1] + words[2]);

        words[0] = 16'h0001; words[1] = 16'hFFFF;
        run_session(2, 1, 0, 16'h0000);
        run_session(2, 1, 0, 16'h0001);

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 5);
            s = '0;
            for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
            for (int i = 0; i < n; i++) s = s + words[i];
            if ($urandom_range(0, 1) == 1) s = s + 16'($urandom_range(1, 65535));
            run_session(n, ($urandom_range(0, 3) != 0), 1'($urandom), s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/my_boot_loader.md
# my_boot_loader

Boot sequencer for the Hack CPU.
- Holds the CPU in reset while a word stream is received over a valid/ready handshake.
- Writes each word sequentially into instruction ROM starting at address 0.
- After a guard interval, releases the CPU to run from pc 0.
- Sits between the host/serial front end, the instruction ROM write port, and the CPU `reset` input.

## Interface
Parameters:
- `ADDR_W`, 15, ROM address width; capacity is 2^ADDR_W words.
- `HOLD_CYCLES`, 2, cycles `cpu_reset` stays high after the final ROM write is issued; must be ≥1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a load session; honoured in IDLE, RUN and ERROR.
- `in_data` input 16: program word.
- `in_valid` input 1: `in_data` valid.
- `in_last` input 1: qualifies the final word of the session.
- `in_ready` output 1: loader accepts a word this cycle.
- `expected_sum` input 16: reference checksum. Used only under the configuration macro.
- `rom_addr` output ADDR_W: ROM write address.
- `rom_data` output 16: ROM write data.
- `rom_we` output 1: ROM write strobe.
- `cpu_reset` output 1: drives the CPU `reset`.
- `busy` output 1: high in LOAD or HOLD.
- `done` output 1: high in RUN.
- `error` output 1: high in ERROR.
- `word_count` output ADDR_W+1: words accepted in the current/last session.

## Operation
- States: IDLE, LOAD, HOLD, RUN, ERROR. The state is registered; all outputs decode from registered state/data.
- Reset values:
  - State IDLE.
  - `cpu_reset`=1.
  - `in_ready`=0, `rom_we`=0, `rom_addr`=0, `rom_data`=0.
  - `busy`=0, `done`=0, `error`=0, `word_count`=0.
- `cpu_reset` is high in every state except RUN.
- IDLE:
  - `start` → LOAD.
  - Clear the write pointer and `word_count`.
- LOAD:
  - `in_ready`=1.
  - A handshake is `in_valid && in_ready`.
  - Each handshake registers `rom_data`←`in_data`, `rom_addr`←pointer and `rom_we`←1.
  - Each handshake increments the pointer and `word_count`.
  - Without a handshake, `rom_we`←0.
  - `start` is ignored in LOAD.
- End of LOAD:
  - Handshake with `in_last`=1 → HOLD.
  - Handshake at pointer 2^ADDR_W−1 with `in_last`=0 → ERROR (overflow). That word is still written; there is no wrap-around write.
  - A 2^ADDR_W-word image therefore needs `in_last` on word 2^ADDR_W−1.
- HOLD:
  - Down-counter loaded with HOLD_CYCLES−1 on entry.
  - Transition to RUN when the counter is 0.
- RUN:
  - `cpu_reset`=0, `done`=1.
  - `start` → LOAD, with the pointer and `word_count` cleared. `cpu_reset` rises in the next cycle.
- ERROR:
  - `error`=1.
  - `start` → LOAD with `error` cleared.
- `reset` in any state, including mid-LOAD, returns all outputs to their reset values next cycle.
- An in-flight `rom_we` is dropped by `reset`.
- `in_data` ignored outside handshakes.

## Timing
- Handshake in cycle k → `rom_we`=1 with that word in cycle k+1 (one-cycle write latency).
- Back-to-back handshakes give one write per cycle. There are no bubbles and no backpressure in LOAD.
- Last word accepted in cycle k:
  - `in_ready`=0 from cycle k+1.
  - HOLD covers cycles k+1 … k+HOLD_CYCLES.
  - `cpu_reset`=0 from cycle k+HOLD_CYCLES+1.
- The final ROM write (cycle k+1) always precedes reset release, because HOLD_CYCLES ≥1.
- `start` in cycle k while in IDLE/RUN/ERROR: `in_ready`=1 in cycle k+1.

## Configuration
- `MY_BOOT_LOADER_CHECKSUM_EN` defined:
  - Each accepted word is added to a 16-bit wrapping sum, cleared when LOAD is entered.
  - On the `in_last` handshake, compare (sum + `in_data`) mod 2^16 against `expected_sum`.
  - Mismatch → ERROR instead of HOLD. The last word is still written.
- Undefined: `expected_sum` is ignored, no sum logic is built, and `in_last` always → HOLD.

## Test plan
- Reset, then idle 5 cycles → `cpu_reset`=1, `in_ready`=0, `rom_we`=0, `done`=0, `word_count`=0.
- `start`; stream 0x0002, 0xEC10, 0x0003 (`in_last` on third), `in_valid` held → writes at addr 0/1/2 in consecutive cycles. `word_count`=3. `cpu_reset` falls exactly 3 cycles after the last accept (HOLD_CYCLES=2), then `done`=1.
- Same stream with `in_valid` toggling every other cycle → identical ROM contents. `rom_we` only in cycles after handshakes.
- ADDR_W=2: 4 words with no `in_last` → 4 writes (addr 0–3), ERROR, `error`=1, `cpu_reset`=1. Then `start` → LOAD, `error`=0.
- `reset` asserted after 2 of 5 words → next cycle IDLE, `rom_we`=0, `word_count`=0. Subsequent `start` reloads from addr 0.
- With `MY_BOOT_LOADER_CHECKSUM_EN`:
  - Words 0x0001, 0xFFFF with `expected_sum`=0x0000 → RUN.
  - Same words with `expected_sum`=0x0001 → ERROR, `cpu_reset` stays 1.
